// File: rtl/dmem_pkg.sv
// Shared definitions for the RV32I data memory: funct3 codes, FSM states and
// the legality rule for a load/store request.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } dmem_state_t;

   // Loads accept all five sizes; stores only accept the signed codes B/H/W.
   function automatic logic is_legal(input logic we, input logic [2:0] funct3);
      logic ok;
      case (funct3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = ~we;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational lane logic: store byte enables and replicated data, alignment
// check, and load lane selection with sign/zero extension.
module dmem_align
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] word,
   output logic [3:0]  be,
   output logic [31:0] wdata_lanes,
   output logic        misaligned,
   output logic [31:0] rdata
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Store side: byte enables from size/offset, data replicated into every lane.
   always_comb begin
      be          = 4'b0000;
      wdata_lanes = 32'h0000_0000;
      case (funct3)
         F3_B: begin
            be          = 4'b0001 << offset;
            wdata_lanes = {4{wdata[7:0]}};
         end
         F3_H: begin
            be          = offset[1] ? 4'b1100 : 4'b0011;
            wdata_lanes = {2{wdata[15:0]}};
         end
         F3_W: begin
            be          = 4'b1111;
            wdata_lanes = wdata;
         end
         default: begin
            be          = 4'b0000;
            wdata_lanes = 32'h0000_0000;
         end
      endcase
   end

   // Alignment: halves need an even address, words need a 4-byte boundary.
   always_comb begin
      misaligned = 1'b0;
      case (funct3)
         F3_H, F3_HU: misaligned = offset[0];
         F3_W:        misaligned = (offset != 2'b00);
         default:     misaligned = 1'b0;
      endcase
   end

   // Load side: pick the addressed lane and extend to 32 bits.
   always_comb begin
      byte_s = word[{offset, 3'b000} +: 8];
      half_s = offset[1] ? word[31:16] : word[15:0];
      rdata  = 32'h0000_0000;
      case (funct3)
         F3_B:    rdata = {{24{byte_s[7]}}, byte_s};
         F3_H:    rdata = {{16{half_s[15]}}, half_s};
         F3_W:    rdata = word;
         F3_BU:   rdata = {24'h00_0000, byte_s};
         F3_HU:   rdata = {16'h0000, half_s};
         default: rdata = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/data_memory_lsu.sv
// RV32I data memory with a valid/ready request port, byte-lane stores,
// extended loads with a one-cycle registered response, and a post-reset
// sequencer that clears every word before the port opens.
module data_memory_lsu
   import dmem_pkg::*;
#(
   parameter int DEPTH = 256
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        init_done
);

   localparam int AW = $clog2(DEPTH);

   dmem_state_t    state_r;
   dmem_state_t    state_next_s;
   logic [AW-1:0]  clear_idx_r;
   logic [31:0]    mem_r [DEPTH];

   logic [AW-1:0]  word_idx_s;
   logic [1:0]     offset_s;
   logic [31:0]    rword_s;
   logic [3:0]     be_s;
   logic [31:0]    wdata_lanes_s;
   logic           misaligned_s;
   logic [31:0]    load_data_s;
   logic           err_s;
   logic           accept_s;
   logic           store_fire_s;

   logic           resp_valid_r;
   logic [31:0]    resp_rdata_r;
   logic           resp_err_r;

   // Upper address bits are ignored so the space wraps modulo 4*DEPTH bytes.
   logic           unused_addr_s;
   assign unused_addr_s = ^req_addr[31:AW+2];

   assign word_idx_s   = req_addr[AW+1:2];
   assign offset_s     = req_addr[1:0];
   assign rword_s      = mem_r[word_idx_s];
   assign err_s        = ~is_legal(req_we, req_funct3) | misaligned_s;
   // Reset wins over an incoming request: nothing is accepted while rst is high.
   assign accept_s     = req_valid & req_ready & ~rst;
   assign store_fire_s = accept_s & req_we & ~err_s;

   dmem_align u_align (
      .funct3      (req_funct3),
      .offset      (offset_s),
      .wdata       (req_wdata),
      .word        (rword_s),
      .be          (be_s),
      .wdata_lanes (wdata_lanes_s),
      .misaligned  (misaligned_s),
      .rdata       (load_data_s)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= INIT;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next state: leave INIT once the last word has been cleared.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         INIT: begin
            if (clear_idx_r == AW'(DEPTH - 1)) begin
               state_next_s = READY;
            end else begin
               state_next_s = INIT;
            end
         end
         READY:   state_next_s = READY;
         default: state_next_s = INIT;
      endcase
   end

   // FSM outputs: the port opens only after the clear sweep.
   always_comb begin
      req_ready = 1'b0;
      init_done = 1'b0;
      case (state_r)
         INIT: begin
            req_ready = 1'b0;
            init_done = 1'b0;
         end
         READY: begin
            req_ready = 1'b1;
            init_done = 1'b1;
         end
         default: begin
            req_ready = 1'b0;
            init_done = 1'b0;
         end
      endcase
   end

   // Clear-sweep word counter, advancing once per INIT cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         clear_idx_r <= '0;
      end else if (state_r == INIT) begin
         clear_idx_r <= clear_idx_r + AW'(1);
      end
   end

   // Storage: zero one word per INIT cycle, otherwise commit enabled store lanes.
   always_ff @(posedge clk) begin
      if (state_r == INIT) begin
         mem_r[clear_idx_r] <= 32'h0000_0000;
      end else if (store_fire_s) begin
         for (int i = 0; i < 4; i++) begin
            if (be_s[i]) begin
               mem_r[word_idx_s][8*i +: 8] <= wdata_lanes_s[8*i +: 8];
            end
         end
      end
   end

   // Response registers: one response per accept, data only for good loads.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid_r <= 1'b0;
         resp_rdata_r <= 32'h0000_0000;
         resp_err_r   <= 1'b0;
      end else begin
         resp_valid_r <= accept_s;
         resp_err_r   <= accept_s & err_s;
         resp_rdata_r <= (accept_s & ~req_we & ~err_s) ? load_data_s : 32'h0000_0000;
      end
   end

   assign resp_valid = resp_valid_r;
   assign resp_rdata = resp_rdata_r;
   assign resp_err   = resp_err_r;

endmodule
